// File: rtl/wb_port_sequencer.sv
// Writeback sequencer: turns one- or two-slot execute results into writes on a single register-file port.
// Optional macro WB_SIM_END_EN enables the sim_done pulse that follows the final write of a req_sim_end request.
module wb_port_sequencer #(
  parameter  int DW    = 64,
  parameter  int NREGS = 16,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dst0_en,
  input  logic             req_dst1_en,
  input  logic [IW-1:0]    req_dst0,
  input  logic [IW-1:0]    req_dst1,
  input  logic [DW-1:0]    req_data0,
  input  logic [DW-1:0]    req_data1,
  input  logic             req_sim_end,
  input  logic             claim_valid,
  input  logic [IW-1:0]    claim_idx,
  output logic             wr_en,
  output logic [IW-1:0]    wr_idx,
  output logic [DW-1:0]    wr_data,
  output logic [NREGS-1:0] busy_mask,
  output logic             sim_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR0  = 2'd1;
  localparam logic [1:0] WR1  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IW-1:0]    r_dst0;
  logic [IW-1:0]    r_dst1;
  logic [DW-1:0]    r_data0;
  logic [DW-1:0]    r_data1;
  logic             r_en1;
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic             w_last;
  logic             w_xfer;

  // The buffer may be refilled in the same cycle it issues its last write.
  assign w_last    = (r_state == WR1) || ((r_state == WR0) && !r_en1);
  assign req_ready = (r_state == IDLE) || w_last;
  assign w_xfer    = req_valid && req_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = IDLE;
    if (w_xfer) begin
      if (req_dst0_en)      w_state_nxt = WR0;
      else if (req_dst1_en) w_state_nxt = WR1;
      else                  w_state_nxt = IDLE;
    end else if ((r_state == WR0) && r_en1) begin
      w_state_nxt = WR1;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    case (r_state)
      WR0: begin
        wr_en   = 1'b1;
        wr_idx  = r_dst0;
        wr_data = r_data0;
      end
      WR1: begin
        wr_en   = 1'b1;
        wr_idx  = r_dst1;
        wr_data = r_data1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_dst0  <= '0;
      r_dst1  <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_en1   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_dst0  <= req_dst0;
        r_dst1  <= req_dst1;
        r_data0 <= req_data0;
        r_data1 <= req_data1;
        r_en1   <= req_dst1_en;
      end
    end
  end

  // Claims are applied after clears so a same-cycle claim keeps the register busy.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (claim_valid) w_set = NREGS'(1) << claim_idx;
    if (wr_en)       w_clr = NREGS'(1) << wr_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign busy_mask = r_busy;

`ifdef WB_SIM_END_EN
  logic r_sim_end;
  logic r_sim_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sim_end  <= 1'b0;
      r_sim_done <= 1'b0;
    end else begin
      if (w_xfer) r_sim_end <= req_sim_end;
      r_sim_done <= (w_last && r_sim_end) ||
                    (w_xfer && req_sim_end && !req_dst0_en && !req_dst1_en);
    end
  end

  assign sim_done = r_sim_done;
`else
  logic w_unused_sim_end;
  assign w_unused_sim_end = req_sim_end;
  assign sim_done         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Scoreboard bench for wb_port_sequencer: the driver predicts writes/busy/sim_done from request timing rules,
// and a negedge monitor pops and compares whenever the port writes.
module tb_wb_port_sequencer;
  localparam int DW    = 64;
  localparam int NREGS = 16;
  localparam int IW    = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_dst0_en;
  logic             req_dst1_en;
  logic [IW-1:0]    req_dst0;
  logic [IW-1:0]    req_dst1;
  logic [DW-1:0]    req_data0;
  logic [DW-1:0]    req_data1;
  logic             req_sim_end;
  logic             claim_valid;
  logic [IW-1:0]    claim_idx;
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [DW-1:0]    wr_data;
  logic [NREGS-1:0] busy_mask;
  logic             sim_done;

  wb_port_sequencer #(.DW(DW), .NREGS(NREGS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dst0_en (req_dst0_en),
    .req_dst1_en (req_dst1_en),
    .req_dst0    (req_dst0),
    .req_dst1    (req_dst1),
    .req_data0   (req_data0),
    .req_data1   (req_data1),
    .req_sim_end (req_sim_end),
    .claim_valid (claim_valid),
    .claim_idx   (claim_idx),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .busy_mask   (busy_mask),
    .sim_done    (sim_done)
  );

  always #5 clk = ~clk;

  // Cycle c spans posedge c to posedge c+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             idx;
    logic [DW-1:0]  data;
    int             cyc;
  } wr_t;

  wr_t              exp_q[$];
  bit               exp_done[int];
  logic [NREGS-1:0] model_busy = '0;
  int               last_write = -1000;
  int               n_pass = 0;
  int               n_total = 0;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  // One cycle of stimulus; the model accepts when the previous request has issued its last write.
  task automatic drive(input bit v, input bit e0, input int d0, input logic [DW-1:0] x0,
                       input bit e1, input int d1, input logic [DW-1:0] x1,
                       input bit se, input bit cv, input int ci);
    bit model_rdy;
    int n;
    @(posedge clk);
    #1;
    req_valid   = v;
    req_dst0_en = e0;
    req_dst0    = IW'(d0);
    req_data0   = x0;
    req_dst1_en = e1;
    req_dst1    = IW'(d1);
    req_data1   = x1;
    req_sim_end = se;
    claim_valid = cv;
    claim_idx   = IW'(ci);
    model_rdy   = (cyc >= last_write);
    check("req_ready", {63'd0, req_ready}, {63'd0, model_rdy});
    if (v && model_rdy) begin
      n = cyc;
      if (e0) begin n++; exp_q.push_back('{d0, x0, n}); end
      if (e1) begin n++; exp_q.push_back('{d1, x1, n}); end
      last_write = n;
      if (se) exp_done[n + 1] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0, 0, 0, '0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  clr;
    bit  exp_sd;
    if (mon_en) begin
      clr = -1;
      check("busy_mask", 64'(busy_mask), 64'(model_busy));
`ifdef WB_SIM_END_EN
      exp_sd = exp_done.exists(cyc);
`else
      exp_sd = 1'b0;
`endif
      check("sim_done", {63'd0, sim_done}, {63'd0, exp_sd});
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("wr_en_unexpected", {63'd0, wr_en}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_idx", 64'(wr_idx), 64'(e.idx));
          check("wr_data", wr_data, e.data);
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          clr = e.idx;
        end
      end else begin
        check("wr_idx_idle", 64'(wr_idx), 64'd0);
        check("wr_data_idle", wr_data, 64'd0);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          check("wr_en_missing", {63'd0, wr_en}, 64'd1);
          e = exp_q.pop_front();
          clr = e.idx;
        end
      end
      if (clr >= 0) model_busy[clr] = 1'b0;
      if (claim_valid) model_busy[claim_idx] = 1'b1;
    end
  end

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_dst0_en = 1'b0;
    req_dst1_en = 1'b0;
    req_dst0    = '0;
    req_dst1    = '0;
    req_data0   = '0;
    req_data1   = '0;
    req_sim_end = 1'b0;
    claim_valid = 1'b0;
    claim_idx   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_wr_idx", 64'(wr_idx), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    check("rst_sim_done", {63'd0, sim_done}, 64'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Directed cases
    drive(1, 1, 3, 64'hAA, 0, 0, '0, 0, 0, 0);
    idle(2);
    drive(1, 1, 0, 64'h10, 1, 2, 64'h20, 0, 0, 0);
    idle(3);
    drive(0, 0, 0, '0, 0, 0, '0, 0, 1, 5);
    drive(1, 1, 5, 64'h55, 0, 0, '0, 0, 0, 0);
    drive(0, 0, 0, '0, 0, 0, '0, 0, 1, 5);
    idle(2);
    drive(1, 1, 5, 64'h66, 0, 0, '0, 0, 0, 0);
    idle(2);
    drive(1, 1, 1, 64'h101, 0, 0, '0, 0, 0, 0);
    drive(1, 1, 4, 64'h104, 0, 0, '0, 0, 0, 0);
    drive(1, 1, 7, 64'h107, 0, 0, '0, 0, 0, 0);
    idle(2);
    drive(1, 1, 9, 64'h1, 1, 9, 64'h2, 0, 1, 9);
    idle(3);
    drive(1, 0, 0, '0, 0, 0, '0, 1, 0, 0);
    idle(2);
    drive(1, 1, 10, 64'hA0, 1, 11, 64'hB0, 1, 0, 0);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 1'($urandom), $urandom_range(0, NREGS - 1),
            {$urandom, $urandom}, 1'($urandom), $urandom_range(0, NREGS - 1),
            {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) < 4), $urandom_range(0, NREGS - 1));
    end
    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset while the first write of a two-slot request is on the port
    drive(0, 0, 0, '0, 0, 0, '0, 0, 1, 6);
    drive(1, 1, 12, 64'hC, 1, 13, 64'hD, 0, 1, 8);
    @(posedge clk);
    #1;
    mon_en      = 1'b0;
    req_valid   = 1'b0;
    claim_valid = 1'b0;
    #1;
    check("wr0_wr_en", {63'd0, wr_en}, 64'd1);
    check("wr0_wr_idx", 64'(wr_idx), 64'd12);
    check("wr0_ready", {63'd0, req_ready}, 64'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_wr_en", {63'd0, wr_en}, 64'd0);
    check("midrst_wr_idx", 64'(wr_idx), 64'd0);
    check("midrst_wr_data", wr_data, 64'd0);
    check("midrst_busy", 64'(busy_mask), 64'd0);
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_sim_done", {63'd0, sim_done}, 64'd0);
    exp_q.delete();
    exp_done.delete();
    model_busy = '0;
    last_write = -1000;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    idle(4);
    drive(1, 1, 2, 64'hBEEF, 0, 0, '0, 0, 0, 0);
    idle(3);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
